// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, load/store and memory-port signals of
//          mem_port_arbiter into one interface.
// Ports (signals):
//   fetch side : ifReq, ifAddr -> ifRdata, ifAck
//   data side  : dReq, dWe, dAddr, dWdata -> dRdata, dAck
//   memory side: sel, memReq, memWe, memAddr, memWdata <- memRdata, memReady
//   status     : err
// Modports: slave = arbiter view, master = CPU/memory environment view.
interface mem_port_arbiter_if #(
  parameter int unsigned dataWidth = 64,
  parameter int unsigned addrWidth = 64
);
  logic                 ifReq;
  logic [addrWidth-1:0] ifAddr;
  logic [dataWidth-1:0] ifRdata;
  logic                 ifAck;
  logic                 dReq;
  logic                 dWe;
  logic [addrWidth-1:0] dAddr;
  logic [dataWidth-1:0] dWdata;
  logic [dataWidth-1:0] dRdata;
  logic                 dAck;
  logic                 sel;
  logic                 memReq;
  logic                 memWe;
  logic [addrWidth-1:0] memAddr;
  logic [dataWidth-1:0] memWdata;
  logic [dataWidth-1:0] memRdata;
  logic                 memReady;
  logic                 err;

  modport slave (
    input  ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata, memReady,
    output ifRdata, ifAck, dRdata, dAck, sel, memReq, memWe, memAddr,
           memWdata, err
  );

  modport master (
    output ifReq, ifAddr, dReq, dWe, dAddr, dWdata, memRdata, memReady,
    input  ifRdata, ifAck, dRdata, dAck, sel, memReq, memWe, memAddr,
           memWdata, err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: round-robin arbiter sharing one memory port between instruction
//          fetch and load/store. Sequences request/ready, returns read data
//          to the winner and raises a sticky error on memory timeout.
// Ports:
//   clk  - clock, all state on rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave (fetch, data and memory-port signals)
module mem_port_arbiter #(
  parameter int unsigned dataWidth = 64,
  parameter int unsigned addrWidth = 64,
  parameter int unsigned maxWait   = 15
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned WaitW = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic                 r_sel, w_sel_nxt;
  logic                 r_mem_req, w_mem_req_nxt;
  logic                 r_mem_we, w_mem_we_nxt;
  logic [addrWidth-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [dataWidth-1:0] r_mem_wdata, w_mem_wdata_nxt;
  logic [dataWidth-1:0] r_if_rdata, w_if_rdata_nxt;
  logic [dataWidth-1:0] r_d_rdata, w_d_rdata_nxt;
  logic                 r_if_ack, w_if_ack_nxt;
  logic                 r_d_ack, w_d_ack_nxt;
  logic                 r_err, w_err_nxt;
  logic [WaitW-1:0]     r_wait_cnt, w_wait_cnt_nxt;
  // 1 = data won last, 0 = fetch won last
  logic                 r_last_grant, w_last_grant_nxt;

  logic w_any_req;
  logic w_pick_d;
  logic w_timeout;

  assign w_any_req = bus.ifReq | bus.dReq;
  // Data wins when alone, or on a tie when fetch was granted last.
  assign w_pick_d  = bus.dReq & (~bus.ifReq | ~r_last_grant);
  assign w_timeout = (r_wait_cnt == WaitW'(maxWait - 1));

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_sel        <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_d_rdata    <= '0;
      r_if_ack     <= 1'b0;
      r_d_ack      <= 1'b0;
      r_err        <= 1'b0;
      r_wait_cnt   <= '0;
      r_last_grant <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_if_ack     <= w_if_ack_nxt;
      r_d_ack      <= w_d_ack_nxt;
      r_err        <= w_err_nxt;
      r_wait_cnt   <= w_wait_cnt_nxt;
      r_last_grant <= w_last_grant_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_GRANT;
      S_GRANT: if (bus.memReady || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; acks default low so they last one cycle.
  always_comb begin
    w_sel_nxt        = r_sel;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_if_rdata_nxt   = r_if_rdata;
    w_d_rdata_nxt    = r_d_rdata;
    w_if_ack_nxt     = 1'b0;
    w_d_ack_nxt      = 1'b0;
    w_err_nxt        = r_err;
    w_wait_cnt_nxt   = r_wait_cnt;
    w_last_grant_nxt = r_last_grant;
    case (r_state)
      S_IDLE: begin
        if (w_any_req) begin
          w_sel_nxt        = w_pick_d;
          w_mem_addr_nxt   = w_pick_d ? bus.dAddr : bus.ifAddr;
          w_mem_we_nxt     = w_pick_d & bus.dWe;
          if (w_pick_d) w_mem_wdata_nxt = bus.dWdata;
          w_mem_req_nxt    = 1'b1;
          w_wait_cnt_nxt   = '0;
          w_last_grant_nxt = w_pick_d;
        end
      end
      S_GRANT: begin
        if (bus.memReady || w_timeout) begin
          w_mem_req_nxt = 1'b0;
          if (r_sel) begin
            w_d_rdata_nxt = bus.memReady ? bus.memRdata : '0;
            w_d_ack_nxt   = 1'b1;
          end else begin
            w_if_rdata_nxt = bus.memReady ? bus.memRdata : '0;
            w_if_ack_nxt   = 1'b1;
          end
          if (!bus.memReady) w_err_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WaitW'(1);
        end
      end
      default: ;
    endcase
  end

  assign bus.sel      = r_sel;
  assign bus.memReq   = r_mem_req;
  assign bus.memWe    = r_mem_we;
  assign bus.memAddr  = r_mem_addr;
  assign bus.memWdata = r_mem_wdata;
  assign bus.ifRdata  = r_if_rdata;
  assign bus.dRdata   = r_d_rdata;
  assign bus.ifAck    = r_if_ack;
  assign bus.dAck     = r_d_ack;
  assign bus.err      = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned AW = 64;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.dataWidth(DW), .addrWidth(AW)) bus ();

  mem_port_arbiter #(.dataWidth(DW), .addrWidth(AW), .maxWait(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ifReq = 1'b0; bus.dReq = 1'b0; bus.dWe = 1'b0; bus.memReady = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    bool_init: begin
      bus.ifReq = 1'b0; bus.ifAddr = '0; bus.dReq = 1'b0; bus.dWe = 1'b0;
      bus.dAddr = '0; bus.dWdata = '0; bus.memRdata = '0; bus.memReady = 1'b0;
      rst = 1'b1;
    end
    do_reset();

    // Reset state
    check_eq("rst_sel", 64'(bus.sel), 64'd0);
    check_eq("rst_memreq", 64'(bus.memReq), 64'd0);
    check_eq("rst_memwe", 64'(bus.memWe), 64'd0);
    check_eq("rst_acks", 64'({bus.ifAck, bus.dAck}), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
    check_eq("rst_memaddr", bus.memAddr, 64'd0);
    check_eq("rst_memwdata", bus.memWdata, 64'd0);
    check_eq("rst_rdata", bus.ifRdata | bus.dRdata, 64'd0);

    // 1: single fetch, memReady two cycles after memReq
    bus.ifReq = 1'b1; bus.ifAddr = 64'h100; bus.memRdata = 64'hDEADBEEF;
    tick();
    check_eq("t1_memreq", 64'(bus.memReq), 64'd1);
    check_eq("t1_memaddr", bus.memAddr, 64'h100);
    check_eq("t1_sel", 64'(bus.sel), 64'd0);
    check_eq("t1_memwe", 64'(bus.memWe), 64'd0);
    tick();
    check_eq("t1_wait_noack", 64'(bus.ifAck), 64'd0);
    tick();
    bus.memReady = 1'b1;
    tick();
    check_eq("t1_ifack", 64'(bus.ifAck), 64'd1);
    check_eq("t1_ifrdata", bus.ifRdata, 64'hDEADBEEF);
    check_eq("t1_dack", 64'(bus.dAck), 64'd0);
    check_eq("t1_memreq_low", 64'(bus.memReq), 64'd0);
    bus.ifReq = 1'b0; bus.memReady = 1'b0;
    tick();
    check_eq("t1_ack_pulse", 64'(bus.ifAck), 64'd0);

    // 2: tie after reset, memReady immediate
    do_reset();
    bus.ifReq = 1'b1; bus.dReq = 1'b1; bus.dWe = 1'b0;
    bus.ifAddr = 64'h10; bus.dAddr = 64'h20;
    bus.memReady = 1'b1; bus.memRdata = 64'hA1A1;
    tick();
    check_eq("t2_sel_fetch", 64'(bus.sel), 64'd0);
    check_eq("t2_addr_fetch", bus.memAddr, 64'h10);
    tick();
    check_eq("t2_ifack", 64'(bus.ifAck), 64'd1);
    check_eq("t2_ifrdata", bus.ifRdata, 64'hA1A1);
    check_eq("t2_dack_c2", 64'(bus.dAck), 64'd0);
    bus.ifReq = 1'b0;
    tick();
    check_eq("t2_idle_memreq", 64'(bus.memReq), 64'd0);
    check_eq("t2_sel_held", 64'(bus.sel), 64'd0);
    bus.memRdata = 64'hB2B2;
    tick();
    check_eq("t2_sel_data", 64'(bus.sel), 64'd1);
    check_eq("t2_addr_data", bus.memAddr, 64'h20);
    tick();
    check_eq("t2_dack", 64'(bus.dAck), 64'd1);
    check_eq("t2_drdata", bus.dRdata, 64'hB2B2);
    check_eq("t2_ifack_c5", 64'(bus.ifAck), 64'd0);
    bus.dReq = 1'b0;
    tick();

    // 3: fairness with both requesters re-requesting after each ack
    bus.ifReq = 1'b1; bus.dReq = 1'b1; bus.memReady = 1'b1;
    for (int t = 0; t < 4; t++) begin
      logic exp_d;
      exp_d = 1'(t % 2);
      bus.memRdata = 64'(32'hC000 + t);
      tick();
      check_eq($sformatf("t3_sel_%0d", t), 64'(bus.sel), 64'(exp_d));
      tick();
      check_eq($sformatf("t3_acks_%0d", t), 64'({bus.ifAck, bus.dAck}),
               exp_d ? 64'd1 : 64'd2);
      check_eq($sformatf("t3_rdata_%0d", t), exp_d ? bus.dRdata : bus.ifRdata,
               64'(32'hC000 + t));
      if (exp_d) bus.dReq = 1'b0; else bus.ifReq = 1'b0;
      tick();
      bus.ifReq = 1'b1; bus.dReq = 1'b1;
    end
    bus.ifReq = 1'b0; bus.dReq = 1'b0; bus.memReady = 1'b0;
    tick(); tick(); tick();

    // 4: store held stable until memReady
    bus.dReq = 1'b1; bus.dWe = 1'b1; bus.dAddr = 64'h2000; bus.dWdata = 64'h1234;
    tick();
    check_eq("t4_memwe", 64'(bus.memWe), 64'd1);
    check_eq("t4_memaddr", bus.memAddr, 64'h2000);
    check_eq("t4_memwdata", bus.memWdata, 64'h1234);
    check_eq("t4_sel", 64'(bus.sel), 64'd1);
    bus.dAddr = 64'hFFFF; bus.dWdata = 64'hEEEE;
    tick();
    check_eq("t4_addr_held", bus.memAddr, 64'h2000);
    check_eq("t4_wdata_held", bus.memWdata, 64'h1234);
    check_eq("t4_memreq_held", 64'(bus.memReq), 64'd1);
    bus.memReady = 1'b1; bus.memRdata = 64'h55;
    tick();
    check_eq("t4_dack", 64'(bus.dAck), 64'd1);
    check_eq("t4_ifack", 64'(bus.ifAck), 64'd0);
    bus.dReq = 1'b0; bus.dWe = 1'b0; bus.memReady = 1'b0;
    tick();
    check_eq("t4_dack_pulse", 64'(bus.dAck), 64'd0);
    tick();

    // 5: fetch timeout, memReady never asserted
    bus.ifReq = 1'b1; bus.ifAddr = 64'h300; bus.memRdata = 64'hFFFF;
    tick();
    cnt = 0;
    while (bus.memReq === 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    check_eq("t5_memreq_cycles", 64'(cnt), 64'd15);
    check_eq("t5_ifack", 64'(bus.ifAck), 64'd1);
    check_eq("t5_ifrdata_zero", bus.ifRdata, 64'd0);
    check_eq("t5_err", 64'(bus.err), 64'd1);
    bus.ifReq = 1'b0;
    tick();
    bus.ifReq = 1'b1; bus.ifAddr = 64'h308; bus.memReady = 1'b1; bus.memRdata = 64'h77;
    tick();
    tick();
    check_eq("t5_good_ifack", 64'(bus.ifAck), 64'd1);
    check_eq("t5_good_rdata", bus.ifRdata, 64'h77);
    check_eq("t5_err_sticky", 64'(bus.err), 64'd1);
    bus.ifReq = 1'b0; bus.memReady = 1'b0;
    tick();

    // 6: reset while in GRANT
    bus.ifReq = 1'b1; bus.ifAddr = 64'h400;
    tick();
    check_eq("t6_memreq_pre", 64'(bus.memReq), 64'd1);
    rst = 1'b1;
    tick();
    check_eq("t6_memreq_rst", 64'(bus.memReq), 64'd0);
    check_eq("t6_acks_rst", 64'({bus.ifAck, bus.dAck}), 64'd0);
    check_eq("t6_err_rst", 64'(bus.err), 64'd0);
    rst = 1'b0; bus.ifReq = 1'b0;
    tick();
    check_eq("t6_no_ack", 64'({bus.ifAck, bus.dAck}), 64'd0);
    bus.ifReq = 1'b1; bus.dReq = 1'b1; bus.memReady = 1'b1;
    bus.ifAddr = 64'h500; bus.dAddr = 64'h600;
    tick();
    check_eq("t6_tie_sel", 64'(bus.sel), 64'd0);
    check_eq("t6_tie_addr", bus.memAddr, 64'h500);
    tick();
    check_eq("t6_tie_ifack", 64'(bus.ifAck), 64'd1);
    bus.ifReq = 1'b0; bus.dReq = 1'b0; bus.memReady = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 64-bit memory port between the instruction-fetch path and the load/store path of the CPU. Picks one requester per transaction with round-robin fairness and drives the port-side 2:1 datapath mux select. Sequences each request/ready handshake, returns read data to the winner, and reports a sticky timeout error if memory never answers.

Parameters:
dataWidth, 64, width of read/write data
addrWidth, 64, width of addresses
maxWait, 15, cycles memReq may stay asserted without memReady before timeout (1..255)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
ifReq  input  1  fetch request, held high until ifAck
ifAddr  input  addrWidth  fetch address
ifRdata  output  dataWidth  fetch read data, valid when ifAck=1
ifAck  output  1  one-cycle fetch completion pulse
dReq  input  1  data request, held high until dAck
dWe  input  1  1 = store, 0 = load
dAddr  input  addrWidth  data address
dWdata  input  dataWidth  store data
dRdata  output  dataWidth  load data, valid when dAck=1
dAck  output  1  one-cycle data completion pulse
sel  output  1  port mux select: 0 = fetch, 1 = data
memReq  output  1  memory request
memWe  output  1  memory write enable
memAddr  output  addrWidth  memory address
memWdata  output  dataWidth  memory write data
memRdata  input  dataWidth  memory read data, valid with memReady
memReady  input  1  memory completion, sampled only while memReq=1
err  output  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock clk; rst is synchronous and active-high. All outputs registered.
- Reset values: state=IDLE; sel, memReq, memWe, ifAck, dAck, err = 0; memAddr, memWdata, ifRdata, dRdata = 0; waitCnt=0; lastGrant=1, so fetch wins the first tie.
- States: IDLE, GRANT, DONE.
- IDLE: requests are sampled only in this state.
  - If exactly one request is high, that requester is granted.
  - If both are high, the requester opposite lastGrant is granted.
  - On a grant, at the next edge: set sel, latch address and, for data, dWe/dWdata into memAddr/memWe/memWdata; memReq=1; waitCnt=0; update lastGrant; go to GRANT. Fetch always drives memWe=0.
  - If no request is high, stay in IDLE.
- GRANT: memAddr, memWe, memWdata and sel are held stable.
  - memReady=1: latch memRdata into the winner's rdata (also on stores, with value ignored by the requester); memReq=0; winner's ack=1; go to DONE.
  - memReady=0 and waitCnt=maxWait-1: timeout. Winner's rdata=0; ack=1; err=1; memReq=0; go to DONE.
  - Otherwise waitCnt increments.
- DONE: ack is high for exactly this one cycle; next state is IDLE. The requester must drop req in the cycle after it sees ack. This guarantees no double grant.
- Dropping req while in GRANT is ignored; the transaction completes and the ack still pulses.
- Latency: req high in cycle 0 → memReq in cycle 1. If memReady comes in cycle 1, ack is in cycle 2. Minimum issue interval is 3 cycles per transaction.
- sel keeps its last value in IDLE and DONE. It changes only at a grant edge, never while memReq=1.
- err is cleared only by rst.
- Reset mid-transaction: returns to IDLE next edge, memReq drops, no ack is issued, and lastGrant returns to 1.
- ifAck and dAck are never high in the same cycle.

Test Plan:
1. Single fetch: ifReq=1, ifAddr=0x100; memReady=1 two cycles after memReq with memRdata=0xDEADBEEF → memAddr=0x100, sel=0, memWe=0; ifAck one cycle later with ifRdata=0xDEADBEEF; dAck stays 0.
2. Tie after reset: ifReq and dReq rise together, memReady immediate → fetch granted first (sel=0, ifAck at cycle 2), then data (sel=1, dAck at cycle 5).
3. Fairness: both requests held continuously with re-request after each ack, 4 transactions → grant order fetch, data, fetch, data; no requester starves.
4. Store: dReq=1, dWe=1, dAddr=0x2000, dWdata=0x1234 → memWe=1, memAddr=0x2000, memWdata=0x1234, sel=1, held stable until memReady; dAck one pulse.
5. Timeout (maxWait=15): fetch granted, memReady never asserted → memReq high exactly 15 cycles, then ifAck=1 with ifRdata=0, err=1. err stays 1 through later good transactions until rst.
6. Reset mid-grant: assert rst while in GRANT with memReq=1 → next edge memReq=0, no ack, err=0. A subsequent tie grants fetch first.
